// File: rtl/sliding_window_builder.sv
// Sliding window builder: assembles a KernelWidth x KernelWidth window per channel from the
// current pixel plus line-delayed pixels, presenting only fully populated windows downstream.
module sliding_window_builder #(
  parameter int BufferWidth   = 8,
  parameter int KernelWidth   = 3,
  parameter int InputChannels = 2,
  parameter int LineWidth     = 8,
  parameter int FrameHeight   = 4
) (
  input  logic                                                                  clk_i,
  input  logic                                                                  rst_ni,
  input  logic [InputChannels-1:0][BufferWidth-1:0]                             data_i,
  input  logic [InputChannels-1:0][KernelWidth-2:0][BufferWidth-1:0]            rows_i,
  input  logic                                                                  valid_i,
  output logic                                                                  ready_o,
  output logic [InputChannels-1:0][KernelWidth-1:0][KernelWidth-1:0][BufferWidth-1:0] window_o,
  output logic                                                                  frame_last_o,
  output logic                                                                  valid_o,
  input  logic                                                                  ready_i
);

  localparam int ColW = (LineWidth > 1) ? $clog2(LineWidth) : 1;
  localparam int RowW = (FrameHeight > 1) ? $clog2(FrameHeight) : 1;

  localparam logic [ColW-1:0] ColLast  = ColW'(LineWidth - 1);
  localparam logic [RowW-1:0] RowLast  = RowW'(FrameHeight - 1);
  localparam logic [ColW-1:0] ColFirst = ColW'(KernelWidth - 1);
  localparam logic [RowW-1:0] RowFirst = RowW'(KernelWidth - 1);

  logic [InputChannels-1:0][KernelWidth-1:0][KernelWidth-1:0][BufferWidth-1:0] r_win;
  logic [ColW-1:0] r_col;
  logic [RowW-1:0] r_row;
  logic            r_valid;
  logic            r_last;

  logic w_in_fire;
  logic w_out_fire;
  logic w_col_last;
  logic w_row_last;
  logic w_win_ok;

  assign ready_o    = !r_valid || ready_i;
  assign w_in_fire  = valid_i && ready_o;
  assign w_out_fire = r_valid && ready_i;
  assign w_col_last = (r_col == ColLast);
  assign w_row_last = (r_row == RowLast);
  // Gating on both counters keeps stale line-buffer rows and line-spanning windows hidden.
  assign w_win_ok   = (r_col >= ColFirst) && (r_row >= RowFirst);

  // NOTE: the window is a small register bank, so it is reset along with the control state;
  // a reset clears window_o and guarantees nothing from an aborted frame is visible.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_win <= '0;
    end else if (w_in_fire) begin
      for (int ch = 0; ch < InputChannels; ch++) begin
        for (int c = 0; c < KernelWidth - 1; c++) begin
          for (int r = 0; r < KernelWidth; r++) begin
            r_win[ch][r][c] <= r_win[ch][r][c+1];
          end
        end
        r_win[ch][KernelWidth-1][KernelWidth-1] <= data_i[ch];
        for (int k = 0; k < KernelWidth - 1; k++) begin
          r_win[ch][KernelWidth-2-k][KernelWidth-1] <= rows_i[ch][k];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the counters regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_in_fire) begin
      r_col <= w_col_last ? '0 : r_col + ColW'(1);
      if (w_col_last) begin
        r_row <= w_row_last ? '0 : r_row + RowW'(1);
      end
    end
  end

  // A new beat always wins over draining the current one, giving no bubble on replacement.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end else if (w_in_fire) begin
      r_valid <= w_win_ok;
      r_last  <= w_col_last && w_row_last;
    end else if (w_out_fire) begin
      r_valid <= 1'b0;
      r_last  <= 1'b0;
    end
  end

  assign window_o     = r_win;
  assign valid_o      = r_valid;
  assign frame_last_o = r_last;

endmodule

// File: tb/tb_sliding_window_builder.sv
// Directed self-checking bench for sliding_window_builder: pixel value = row*16+col on ch0,
// bitwise inverse on ch1; expected windows are rebuilt from that formula.
module tb_sliding_window_builder;

  localparam int BW = 8;
  localparam int KW = 3;
  localparam int IC = 2;
  localparam int LW = 8;
  localparam int FH = 4;

  typedef logic [IC-1:0][KW-1:0][KW-1:0][BW-1:0] win_t;

  logic                                clk_i;
  logic                                rst_ni;
  logic [IC-1:0][BW-1:0]               data_i;
  logic [IC-1:0][KW-2:0][BW-1:0]       rows_i;
  logic                                valid_i;
  logic                                ready_o;
  win_t                                window_o;
  logic                                frame_last_o;
  logic                                valid_o;
  logic                                ready_i;

  int n_assert;
  int n_fail;

  sliding_window_builder #(
    .BufferWidth(BW), .KernelWidth(KW), .InputChannels(IC),
    .LineWidth(LW), .FrameHeight(FH)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .data_i      (data_i),
    .rows_i      (rows_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .window_o    (window_o),
    .frame_last_o(frame_last_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [BW-1:0] pix(int ch, int r, int c);
    logic [BW-1:0] p;
    p = BW'(r * 16 + c);
    return (ch == 0) ? p : ~p;
  endfunction

  function automatic win_t exp_win(int r_new, int c_new);
    win_t w;
    for (int ch = 0; ch < IC; ch++)
      for (int r = 0; r < KW; r++)
        for (int c = 0; c < KW; c++)
          w[ch][r][c] = pix(ch, r_new - (KW - 1) + r, c_new - (KW - 1) + c);
    return w;
  endfunction

  // Rows above the frame top are filled with junk the DUT must never expose.
  task automatic set_beat(int r, int c);
    for (int ch = 0; ch < IC; ch++) begin
      data_i[ch] = pix(ch, r, c);
      for (int k = 0; k < KW - 1; k++)
        rows_i[ch][k] = (r - 1 - k >= 0) ? pix(ch, r - 1 - k, c) : 8'hA5;
    end
    valid_i = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni  = 1'b0;
    valid_i = 1'b0;
    ready_i = 1'b1;
    data_i  = '0;
    rows_i  = '0;
    repeat (2) tick();
    n_assert++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_o); end
    n_assert++;
    if (window_o !== '0) begin n_fail++; $display("FAIL reset_window got=%h exp=0", window_o); end
    n_assert++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", ready_o); end
    n_assert++;
    if (frame_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got=%b exp=0", frame_last_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    n_assert++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL post_reset_ready got=%b exp=1", ready_o); end
  endtask

  // Streams one full frame at full rate, checking every beat's window, valid and frame_last.
  task automatic test_frame(int frame_idx);
    int n_win;
    int first_r;
    int first_c;
    bit ok;
    n_win   = 0;
    first_r = -1;
    first_c = -1;
    ready_i = 1'b1;
    for (int r = 0; r < FH; r++) begin
      for (int c = 0; c < LW; c++) begin
        set_beat(r, c);
        tick();
        ok = (r >= KW - 1) && (c >= KW - 1);
        n_assert++;
        if (valid_o !== ok) begin
          n_fail++;
          $display("FAIL frame%0d_valid(r%0d,c%0d) got=%b exp=%b", frame_idx, r, c, valid_o, ok);
        end
        n_assert++;
        if (frame_last_o !== (r == FH - 1 && c == LW - 1)) begin
          n_fail++;
          $display("FAIL frame%0d_last(r%0d,c%0d) got=%b", frame_idx, r, c, frame_last_o);
        end
        if (ok) begin
          n_assert++;
          if (window_o !== exp_win(r, c)) begin
            n_fail++;
            $display("FAIL frame%0d_window(r%0d,c%0d) got=%h exp=%h", frame_idx, r, c, window_o, exp_win(r, c));
          end
          n_assert++;
          if (window_o[1] !== ~window_o[0]) begin
            n_fail++;
            $display("FAIL frame%0d_chan_iso(r%0d,c%0d) ch1=%h ~ch0=%h", frame_idx, r, c, window_o[1], ~window_o[0]);
          end
        end
        if (valid_o === 1'b1) begin
          n_win++;
          if (first_r < 0) begin first_r = r; first_c = c; end
        end
      end
    end
    valid_i = 1'b0;
    tick();
    n_assert++;
    if (n_win != 12) begin n_fail++; $display("FAIL frame%0d_count got=%0d exp=12", frame_idx, n_win); end
    n_assert++;
    if (first_r != 2 || first_c != 2) begin
      n_fail++;
      $display("FAIL frame%0d_first got=(r%0d,c%0d) exp=(r2,c2)", frame_idx, first_r, first_c);
    end
    n_assert++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL frame%0d_drain got=%b exp=0", frame_idx, valid_o); end
  endtask

  task automatic test_backpressure();
    ready_i = 1'b1;
    for (int i = 0; i <= 2 * LW + 2; i++) begin
      set_beat(i / LW, i % LW);
      tick();
    end
    n_assert++;
    if (valid_o !== 1'b1 || window_o !== exp_win(2, 2)) begin
      n_fail++;
      $display("FAIL bp_setup valid=%b window=%h exp=%h", valid_o, window_o, exp_win(2, 2));
    end
    ready_i = 1'b0;
    set_beat(2, 3);
    #1;
    n_assert++;
    if (ready_o !== 1'b0) begin n_fail++; $display("FAIL bp_ready_drop got=%b exp=0", ready_o); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_assert++;
      if (ready_o !== 1'b0 || valid_o !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold_ctrl cyc=%0d ready=%b valid=%b exp ready=0 valid=1", i, ready_o, valid_o);
      end
      n_assert++;
      if (window_o !== exp_win(2, 2)) begin
        n_fail++;
        $display("FAIL bp_hold_window cyc=%0d got=%h exp=%h", i, window_o, exp_win(2, 2));
      end
    end
    ready_i = 1'b1;
    #1;
    n_assert++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready got=%b exp=1", ready_o); end
    tick();
    n_assert++;
    if (valid_o !== 1'b1 || window_o !== exp_win(2, 3)) begin
      n_fail++;
      $display("FAIL bp_replace valid=%b window=%h exp=%h", valid_o, window_o, exp_win(2, 3));
    end
    for (int i = 2 * LW + 4; i < LW * FH; i++) begin
      set_beat(i / LW, i % LW);
      tick();
    end
    n_assert++;
    if (valid_o !== 1'b1 || frame_last_o !== 1'b1 || window_o !== exp_win(3, 7)) begin
      n_fail++;
      $display("FAIL bp_frame_end valid=%b last=%b window=%h", valid_o, frame_last_o, window_o);
    end
    valid_i = 1'b0;
    tick();
  endtask

  // Asynchronous reset while a window is held under backpressure must discard it at once.
  task automatic test_reset_mid();
    ready_i = 1'b1;
    for (int i = 0; i <= 2 * LW + 3; i++) begin
      set_beat(i / LW, i % LW);
      tick();
    end
    valid_i = 1'b0;
    ready_i = 1'b0;
    tick();
    n_assert++;
    if (valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_setup_valid got=%b exp=1", valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    n_assert++;
    if (valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got=%b exp=0", valid_o); end
    n_assert++;
    if (window_o !== '0) begin n_fail++; $display("FAIL mid_reset_window got=%h exp=0", window_o); end
    n_assert++;
    if (ready_o !== 1'b1) begin n_fail++; $display("FAIL mid_reset_ready got=%b exp=1", ready_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    test_reset();
    test_frame(0);
    test_frame(1);
    test_backpressure();
    test_reset_mid();
    test_frame(2);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sliding_window_builder.md
# sliding_window_builder

Assembles a KernelWidth×KernelWidth pixel window per input channel from the current pixel and the KernelWidth-1 line-delayed pixels supplied by the upstream line delay buffer. Sits directly downstream of the line delay buffer and upstream of the convolution/filter datapath. Tracks column and row position within the frame, so only fully populated windows are presented downstream. There is no edge padding; partial windows are suppressed.

## Interface
- BufferWidth, 8, bits per pixel
- KernelWidth, 3, window edge size; ≥2
- InputChannels, 2, independent pixel channels
- LineWidth, 8, pixels per line; ≥KernelWidth; equals the upstream delay depth
- FrameHeight, 4, lines per frame; ≥KernelWidth
- clk_i  in  1  clock; the only clock
- rst_ni  in  1  reset; asynchronous, active-low
- data_i  in  [InputChannels][BufferWidth]  current pixel, one per channel
- rows_i  in  [InputChannels][KernelWidth-1][BufferWidth]  delayed pixels for the same column
  - index 0 is the previous line
  - index KernelWidth-2 is the oldest line
- valid_i  in  1  data_i and rows_i are valid
- ready_o  out  1  block accepts a beat
- window_o  out  [InputChannels][KernelWidth][KernelWidth][BufferWidth]  window indexed [ch][r][c]
  - r=0 is the oldest line; r=KernelWidth-1 is the current line
  - c=0 is the oldest column; c=KernelWidth-1 is the newest column
- frame_last_o  out  1  the presented window contains the last pixel of the frame
- valid_o  out  1  window_o and frame_last_o are valid
- ready_i  in  1  downstream accepts

## Operation
- in_fire = valid_i && ready_o.
- out_fire = valid_o && ready_i.
- ready_o = !valid_o || ready_i. This is a single output register stage, combinational in ready_i.
- Column registers: per channel, KernelWidth columns of KernelWidth pixels each.
- On in_fire, every column shifts toward c=0, and the new column is loaded at c=KernelWidth-1:
  - r=KernelWidth-1 ← data_i[ch]
  - r=KernelWidth-2-k ← rows_i[ch][k]
- The column registers change only on in_fire; they hold otherwise.
- col_r counter:
  - width $clog2(LineWidth); range 0..LineWidth-1
  - increments on in_fire; wraps to 0 after LineWidth-1
- row_r counter:
  - width $clog2(FrameHeight); range 0..FrameHeight-1
  - increments on in_fire when col_r==LineWidth-1; wraps to 0 after FrameHeight-1
- Counter values below are taken before the update on that fire.
- win_ok = (col_r ≥ KernelWidth-1) && (row_r ≥ KernelWidth-1).
- On in_fire:
  - valid_o ← win_ok
  - frame_last_o ← (col_r==LineWidth-1) && (row_r==FrameHeight-1)
- On out_fire without in_fire: valid_o ← 0.
- Simultaneous in_fire and out_fire: the new beat replaces the old one; valid_o takes the new win_ok. No bubble, no loss.
- A beat with win_ok=0 still updates the column registers and counters, and drops valid_o.
- Rows of line-delayed data that are stale at frame start are never exposed:
  - row gating covers lines 0..KernelWidth-2
  - column gating covers the first KernelWidth-1 pixels of every line, so no window spans two lines
- Windows per frame: (LineWidth-KernelWidth+1)·(FrameHeight-KernelWidth+1).

## Timing
- Reset (rst_ni low, asynchronous) clears:
  - valid_o=0, frame_last_o=0, window_o=0
  - col_r=0, row_r=0
- ready_o=1 while in reset and immediately after reset.
- Reset mid-operation discards any held window. The next accepted beat is treated as pixel (0,0) of a new frame.
- Latency: a window appears on window_o/valid_o the cycle after the in_fire of its newest pixel.
- With ready_i held high and valid_i held high, throughput is one beat per cycle.
- Backpressure: while valid_o=1 and ready_i=0:
  - ready_o=0
  - window_o, frame_last_o and valid_o are held stable
  - counters and column registers are frozen
- valid_o never drops without out_fire, except on reset or on a replacement beat with win_ok=0 that arrives in the same cycle as out_fire.
- frame_last_o is meaningful only when valid_o=1, and is 0 whenever valid_o=0 after reset.

## Test plan
- Reset check (defaults): hold rst_ni low mid-stream -> valid_o=0, window_o=0, ready_o=1. The next beat counts as col 0, row 0.
- Frame count (defaults): stream 32 beats with ch0 pixel = row·16+col, ready_i=1 -> exactly 12 valid windows. The first window appears after beat (row2, col2). It has window_o[0] rows {0x00,0x01,0x02}, {0x10,0x11,0x12}, {0x20,0x21,0x22}.
- Line boundary: beats at col 0 and col 1 of rows 2 and 3 -> valid_o=0 on the following cycle, with no window spanning lines.
- frame_last_o: the 12th window (row3, col7) -> frame_last_o=1. All others have frame_last_o=0. A second frame yields 12 more windows, starting again at (row2, col2).
- Backpressure: deassert ready_i for 5 cycles with a valid window held -> ready_o=0 and window_o stable. On release, accept and replace in the same cycle with no gap.
- Channel isolation: drive ch1 = ~ch0 -> every window_o[1] equals the bitwise inverse of window_o[0].
